bcd_scan_counter: RTL and testbench

Four-digit BCD up/down counter with an integrated display-scan generator; it feeds the digit multiplexer and 7-segment cathode decoder stage. It produces the four BCD digits Q1..Q4, the 2-bit digit select Y, and active-low anode enables, all registered on one clock. Count rate and refresh rate come from independent prescalers so one board clock drives both.

---
 rtl/bcd_scan_counter.sv | 123 ++++++++++++
 tb/tb_bcd_scan_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a free-running 4-phase display scan.
// Count and scan rates come from independent prescalers on one clock.
module bcd_scan_counter #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    output logic [3:0] Q1,
    output logic [3:0] Q2,
    output logic [3:0] Q3,
    output logic [3:0] Q4,
    output logic [1:0] Y,
    output logic [3:0] an,
    output logic       rollover
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } scan_state_e;

    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] scan_q;
    logic [3:0]    dig_q [4];
    logic [3:0]    dig_d [4];
    logic          roll_q;
    logic          step;
    logic          carry;
    logic [3:0]    an_q;
    scan_state_e   state_q;

    assign step = en && (tick_q == TICK_LAST);

    always_comb begin
        tick_d = tick_q;
        if (clr) begin
            tick_d = '0;
        end else if (en) begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        end
    end

    // Ripple carry/borrow: a digit only changes while the chain is still live.
    always_comb begin
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dig_d[i] = dig_q[i];
            if (carry) begin
                if (up) begin
                    if (dig_q[i] == 4'd9) begin
                        dig_d[i] = 4'd0;
                    end else begin
                        dig_d[i] = dig_q[i] + 4'd1;
                        carry    = 1'b0;
                    end
                end else begin
                    if (dig_q[i] == 4'd0) begin
                        dig_d[i] = 4'd9;
                    end else begin
                        dig_d[i] = dig_q[i] - 4'd1;
                        carry    = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            roll_q <= 1'b0;
            for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
        end else begin
            tick_q <= tick_d;
            roll_q <= 1'b0;
            if (clr) begin
                for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
            end else if (step) begin
                for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
                roll_q <= carry;
            end
        end
    end

    // Scan keeps running through clr so the display never stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q  <= '0;
            state_q <= S0;
            an_q    <= 4'b1110;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            unique case (state_q)
                S0: begin state_q <= S1; an_q <= 4'b1101; end
                S1: begin state_q <= S2; an_q <= 4'b1011; end
                S2: begin state_q <= S3; an_q <= 4'b0111; end
                S3: begin state_q <= S0; an_q <= 4'b1110; end
            endcase
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    assign Q1       = dig_q[0];
    assign Q2       = dig_q[1];
    assign Q3       = dig_q[2];
    assign Q4       = dig_q[3];
    assign Y        = state_q;
    assign an       = an_q;
    assign rollover = roll_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench: two instances (4/2 and 1/1 prescalers) against an
// integer-count reference model; expectations queued per edge.
module tb_bcd_scan_counter;

    localparam int TDA = 4;
    localparam int SDA = 2;
    localparam int TDB = 1;
    localparam int SDB = 1;
    localparam int NCYC = 12000;

    typedef struct {
        int cnt;
        int tick;
        int scan;
        int y;
        bit roll;
    } mdl_t;

    typedef struct {
        logic [15:0] q;
        logic [1:0]  y;
        logic [3:0]  an;
        logic        roll;
    } exp_t;

    logic clk;
    logic rst_a, en_a, up_a, clr_a;
    logic rst_b, en_b, up_b, clr_b;
    logic [3:0] a_q1, a_q2, a_q3, a_q4, a_an;
    logic [3:0] b_q1, b_q2, b_q3, b_q4, b_an;
    logic [1:0] a_y, b_y;
    logic a_roll, b_roll;

    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    bcd_scan_counter #(.TICK_DIV(TDA), .SCAN_DIV(SDA)) dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .up(up_a), .clr(clr_a),
        .Q1(a_q1), .Q2(a_q2), .Q3(a_q3), .Q4(a_q4),
        .Y(a_y), .an(a_an), .rollover(a_roll)
    );

    bcd_scan_counter #(.TICK_DIV(TDB), .SCAN_DIV(SDB)) dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .up(up_b), .clr(clr_b),
        .Q1(b_q1), .Q2(b_q2), .Q3(b_q3), .Q4(b_q4),
        .Y(b_y), .an(b_an), .rollover(b_roll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the count is a plain integer 0..9999, digits derived on output.
    function automatic mdl_t mstep(mdl_t m, bit rst, bit en, bit up, bit clr,
                                   int td, int sd);
        mdl_t n = m;
        if (rst) begin
            n.cnt = 0; n.tick = 0; n.scan = 0; n.y = 0; n.roll = 0;
            return n;
        end
        if (m.scan == sd - 1) begin
            n.scan = 0;
            n.y = (m.y + 1) % 4;
        end else begin
            n.scan = m.scan + 1;
        end
        n.roll = 0;
        if (clr) begin
            n.cnt = 0;
            n.tick = 0;
        end else if (en) begin
            if (m.tick == td - 1) begin
                n.tick = 0;
                if (up) begin
                    n.roll = (m.cnt == 9999);
                    n.cnt = (m.cnt + 1) % 10000;
                end else begin
                    n.roll = (m.cnt == 0);
                    n.cnt = (m.cnt + 9999) % 10000;
                end
            end else begin
                n.tick = m.tick + 1;
            end
        end
        return n;
    endfunction

    function automatic exp_t mk(mdl_t m);
        exp_t e;
        logic [3:0] one;
        one = 4'b0001;
        e.q = {4'(m.cnt / 1000), 4'((m.cnt / 100) % 10),
               4'((m.cnt / 10) % 10), 4'(m.cnt % 10)};
        e.y = 2'(m.y);
        e.an = ~(one << m.y);
        e.roll = m.roll;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp, input int cyc);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    int mon_cyc = 0;
    exp_t ea, eb;

    always @(posedge clk) begin
        #1;
        mon_cyc++;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("A_digits", {a_q4, a_q3, a_q2, a_q1}, ea.q, mon_cyc);
            chk("A_Y", 16'(a_y), 16'(ea.y), mon_cyc);
            chk("A_an", 16'(a_an), 16'(ea.an), mon_cyc);
            chk("A_rollover", 16'(a_roll), 16'(ea.roll), mon_cyc);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("B_digits", {b_q4, b_q3, b_q2, b_q1}, eb.q, mon_cyc);
            chk("B_Y", 16'(b_y), 16'(eb.y), mon_cyc);
            chk("B_an", 16'(b_an), 16'(eb.an), mon_cyc);
            chk("B_rollover", 16'(b_roll), 16'(eb.roll), mon_cyc);
        end
    end

    mdl_t ma, mb;
    bit done_clr, done_rst;

    initial begin
        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};
        done_clr = 0;
        done_rst = 0;
        {rst_a, en_a, up_a, clr_a} = 4'b1000;
        {rst_b, en_b, up_b, clr_b} = 4'b1000;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            rst_a = 0; en_a = 1; up_a = 1; clr_a = 0;
            if (c < 2) rst_a = 1;
            else if (c < 20) ;
            else if (c < 22) rst_a = 1;
            else if (c < 24) ;
            else if (c < 34) en_a = 0;
            else if (c < 42) ;
            else if (c < 44) rst_a = 1;
            else if (c < 56) up_a = 0;
            else if (c < 72) up_a = 1;
            else if (c < 120) begin
                if (c >= 100 && !done_clr && ma.tick == TDA - 1) begin
                    clr_a = 1;
                    done_clr = 1;
                end
            end else if (c < 200) begin
                if (c >= 150 && !done_rst && ma.y == 2) begin
                    rst_a = 1;
                    done_rst = 1;
                end
            end else begin
                en_a  = ($urandom_range(3) != 0);
                up_a  = $urandom_range(1);
                clr_a = ($urandom_range(49) == 0);
                rst_a = ($urandom_range(199) == 0);
            end
            rst_b = (c < 2);
            en_b  = 1;
            up_b  = (c < 10010);
            clr_b = 0;
            if (c >= 11500) begin
                en_b  = $urandom_range(1);
                clr_b = ($urandom_range(63) == 0);
            end
            ma = mstep(ma, rst_a, en_a, up_a, clr_a, TDA, SDA);
            mb = mstep(mb, rst_b, en_b, up_b, clr_b, TDB, SDB);
            qa.push_back(mk(ma));
            qb.push_back(mk(mb));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d/%0d expected 0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
